train_seq_ctrl: RTL and testbench
=================================

# train_seq_ctrl

Hardware training sequencer that drives a layer's control handshake (`zero_grad`, `run_forward`, `load_backward`, `run_backward`, `update`) through one mini-batch schedule per iteration. It occupies the initiator end of the layer control protocol: it issues requests, waits for the matching `valid_*` returns, and tracks which batch slot feeds the forward and backward data paths. Its outputs fan out to every training layer, and the AND-reduced layer `valid_*` lines return to it.

## Interface

Parameters:
- `BATCH_SIZE`, default 2: mini-batches per iteration; legal range is 1 or more.
- `IDX_W`, default 4: width of the batch index outputs; must satisfy 2^IDX_W ≥ BATCH_SIZE.
- `ITER_W`, default 16: width of the iteration count.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin a run; sampled only in IDLE.
- `num_iter`, input, ITER_W: number of iterations, latched on an accepted `start`.
- `valid_zero_grad`, `valid_forward`, `valid_backward`, `valid_update`, input, 1 each: responder acknowledges.
- `zero_grad`, `run_forward`, `run_backward`, `load_backward`, `update`, output, 1 each: requests, all registered.
- `fwd_idx`, output, IDX_W: batch slot currently presented on the forward data path.
- `bwd_idx`, output, IDX_W: batch slot currently presented on the backward data path.
- `iter_cnt`, output, ITER_W: number of iterations completed in the current run.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when the run ends.

## Operation

- State machine: IDLE → Z_FWD → Z_REL → [LOAD → STEP → STEP_REL] × (BATCH_SIZE−1) → LOADL → BWDL → BWDL_REL → UPD → UPD_REL → (Z_FWD if more iterations, else DONE) → IDLE.
- IDLE: all requests low.
  - On `start` with `num_iter`≠0: latch `num_iter`, clear `iter_cnt`, set `fwd_idx`=0, go to Z_FWD.
  - On `start` with `num_iter`=0: go to DONE directly, with no requests issued.
- Z_FWD: hold `zero_grad`=1 and `run_forward`=1 until `valid_zero_grad & valid_forward`.
- LOAD and LOADL: `load_backward`=1 for exactly one cycle.
- STEP:
  - On entry, `fwd_idx`←k and `bwd_idx`←k−1, where k runs from 1 to BATCH_SIZE−1.
  - Hold `run_forward`=1 and `run_backward`=1 until `valid_forward & valid_backward`.
- BWDL: `bwd_idx`←BATCH_SIZE−1; hold `run_backward`=1 until `valid_backward`.
- UPD: hold `update`=1 until `valid_update`. On leaving UPD_REL, `iter_cnt` increments.
- Return-to-zero handshake (`*_REL` states):
  - In the cycle after the acknowledge is seen, every request of that phase is low.
  - The FSM stays in `*_REL` until every acknowledge of that phase reads 0, then advances.
  - A request is never re-raised while its valid is still high.
- With BATCH_SIZE=1, Z_REL goes directly to LOADL.
- `start` while `busy` is ignored and does not change `num_iter`.
- An acknowledge for a request that is not active is ignored.

## Timing

- Reset values (asynchronous): all requests 0, `fwd_idx`=0, `bwd_idx`=0, `iter_cnt`=0, `busy`=0, `done`=0, state IDLE. Reset mid-run drops every request in the same instant, with no handshake completion.
- Latencies and holds:
  - `start` sampled at edge t: `busy`=1 and `zero_grad`=`run_forward`=1 from t+1.
  - Valid high at edge t: the corresponding requests are 0 from t+1.
  - A request phase begins no earlier than one cycle after its acknowledges are observed low.
  - `load_backward` pulse at cycle c: the following run request rises at c+1.
  - `fwd_idx` and `bwd_idx` are stable throughout each request assertion. They change only on entry to a run state, never while a request is high.
- `done` is high for one cycle after the final UPD_REL, and `busy` drops in that same cycle. A new `start` is accepted in the cycle after `done`.
- Minimum iteration with 1-cycle responders and BATCH_SIZE=2 is fixed by the state walk (Z_FWD through UPD_REL); the bench checks the exact count produced by the implementation against the state list above.
- `iter_cnt` wraps modulo 2^ITER_W; a run never exceeds `num_iter`.

## Test plan

- **Nominal run.** BATCH_SIZE=2, `num_iter`=1, responders ack 3 cycles after request.
  - Required order: {zero_grad+fwd idx0} → load pulse → {fwd idx1 + bwd idx0} → load pulse → {bwd idx1} → update → `done`.
  - Expect `iter_cnt`=1.
- **Multi-iteration run.** `num_iter`=3.
  - Expect three full schedules, each starting with `zero_grad`, and exactly one `done` pulse.
  - Expect `iter_cnt`=3 at `done`.
- **Mismatched acks.** In the STEP phase, `valid_forward` at +2 cycles and `valid_backward` at +40 cycles.
  - Both runs stay high until cycle +40.
  - Responder holds valid high 5 cycles after request drop: the FSM waits, and the next `load_backward` appears only after both valids are low.
- **Reset mid-run.** `rst_n` pulsed low during UPD.
  - All outputs are 0 immediately and the FSM returns to IDLE.
  - A later `start` with `num_iter`=1 completes normally.
- **Boundary cases.**
  - `num_iter`=0: `done` one cycle after `busy`, with no request ever raised.
  - BATCH_SIZE=1: sequence is zero_grad+fwd → load → bwd idx0 → update.
  - `start` pulsed while `busy`: ignored, with no change to the latched count.

Source files
------------

// File: rtl/train_seq_ctrl.sv
// Training sequencer: walks zero_grad/forward/backward/update requests through
// one mini-batch schedule per iteration using return-to-zero handshakes.
module train_seq_ctrl #(
  parameter int BATCH_SIZE = 2,
  parameter int IDX_W      = 4,
  parameter int ITER_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              valid_zero_grad,
  input  logic              valid_forward,
  input  logic              valid_backward,
  input  logic              valid_update,
  output logic              zero_grad,
  output logic              run_forward,
  output logic              run_backward,
  output logic              load_backward,
  output logic              update,
  output logic [IDX_W-1:0]  fwd_idx,
  output logic [IDX_W-1:0]  bwd_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_Z_FWD,
    S_Z_REL,
    S_LOAD,
    S_STEP,
    S_STEP_REL,
    S_LOADL,
    S_BWDL,
    S_BWDL_REL,
    S_UPD,
    S_UPD_REL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    fwd_idx_q, fwd_idx_d;
  logic [IDX_W-1:0]    bwd_idx_q, bwd_idx_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]   num_iter_q, num_iter_d;
  logic                zero_grad_q, zero_grad_d;
  logic                run_forward_q, run_forward_d;
  logic                run_backward_q, run_backward_d;
  logic                load_backward_q, load_backward_d;
  logic                update_q, update_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    fwd_idx_d  = fwd_idx_q;
    bwd_idx_d  = bwd_idx_q;
    iter_cnt_d = iter_cnt_q;
    num_iter_d = num_iter_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_iter_d = num_iter;
          iter_cnt_d = '0;
          if (num_iter != '0) begin
            fwd_idx_d = '0;
            state_d   = S_Z_FWD;
          end else begin
            state_d   = S_DONE;
          end
        end
      end
      S_Z_FWD: begin
        if (valid_zero_grad && valid_forward) state_d = S_Z_REL;
      end
      S_Z_REL: begin
        if (!valid_zero_grad && !valid_forward) begin
          state_d = (BATCH_SIZE > 1) ? S_LOAD : S_LOADL;
        end
      end
      // fwd_idx doubles as the step counter k; bwd trails it by one slot
      S_LOAD: begin
        state_d   = S_STEP;
        fwd_idx_d = fwd_idx_q + IDX_W'(1);
        bwd_idx_d = fwd_idx_q;
      end
      S_STEP: begin
        if (valid_forward && valid_backward) state_d = S_STEP_REL;
      end
      S_STEP_REL: begin
        if (!valid_forward && !valid_backward) begin
          state_d = (fwd_idx_q == LAST_IDX) ? S_LOADL : S_LOAD;
        end
      end
      S_LOADL: begin
        state_d   = S_BWDL;
        bwd_idx_d = LAST_IDX;
      end
      S_BWDL: begin
        if (valid_backward) state_d = S_BWDL_REL;
      end
      S_BWDL_REL: begin
        if (!valid_backward) state_d = S_UPD;
      end
      S_UPD: begin
        if (valid_update) state_d = S_UPD_REL;
      end
      S_UPD_REL: begin
        if (!valid_update) begin
          iter_cnt_d = iter_cnt_q + ITER_W'(1);
          if (iter_cnt_d == num_iter_q) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_Z_FWD;
            fwd_idx_d = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests are decoded from the next state so they register alongside it
    zero_grad_d     = (state_d == S_Z_FWD);
    run_forward_d   = (state_d == S_Z_FWD) || (state_d == S_STEP);
    run_backward_d  = (state_d == S_STEP) || (state_d == S_BWDL);
    load_backward_d = (state_d == S_LOAD) || (state_d == S_LOADL);
    update_d        = (state_d == S_UPD);
    busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d          = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      fwd_idx_q       <= '0;
      bwd_idx_q       <= '0;
      iter_cnt_q      <= '0;
      num_iter_q      <= '0;
      zero_grad_q     <= 1'b0;
      run_forward_q   <= 1'b0;
      run_backward_q  <= 1'b0;
      load_backward_q <= 1'b0;
      update_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      fwd_idx_q       <= fwd_idx_d;
      bwd_idx_q       <= bwd_idx_d;
      iter_cnt_q      <= iter_cnt_d;
      num_iter_q      <= num_iter_d;
      zero_grad_q     <= zero_grad_d;
      run_forward_q   <= run_forward_d;
      run_backward_q  <= run_backward_d;
      load_backward_q <= load_backward_d;
      update_q        <= update_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign zero_grad     = zero_grad_q;
  assign run_forward   = run_forward_q;
  assign run_backward  = run_backward_q;
  assign load_backward = load_backward_q;
  assign update        = update_q;
  assign fwd_idx       = fwd_idx_q;
  assign bwd_idx       = bwd_idx_q;
  assign iter_cnt      = iter_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Bench for train_seq_ctrl: BATCH_SIZE=2 and BATCH_SIZE=1 instances driven by
// delay/hold-configurable responders, checked against a phase-cost model.
module tb_train_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sel;
  logic [15:0] num_iter;
  logic [3:0]  vld;

  logic [1:0]  zg_o, rf_o, rb_o, lb_o, up_o, busy_o, done_o;
  logic [3:0]  fi_o [2];
  logic [3:0]  bi_o [2];
  logic [15:0] ic_o [2];

  logic        zg, rf, rb, lb, up, busy, done;
  logic [3:0]  fi, bi;
  logic [15:0] ic;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned dly  [4];
  int unsigned hold [4];
  int unsigned rcnt [4];
  int unsigned hcnt [4];

  int unsigned busy_cnt, done_cnt, iter_at_done, last_step_len, plen;
  int          ev_q  [$];
  int          exp_q [$];
  logic [4:0]  vec, prev_vec;
  logic [3:0]  r4, prev_r4;
  logic [3:0]  prev_fi, prev_bi;

  train_seq_ctrl #(.BATCH_SIZE(2), .IDX_W(4), .ITER_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .num_iter(num_iter),
    .valid_zero_grad(vld[0]), .valid_forward(vld[1]),
    .valid_backward(vld[2]), .valid_update(vld[3]),
    .zero_grad(zg_o[0]), .run_forward(rf_o[0]), .run_backward(rb_o[0]),
    .load_backward(lb_o[0]), .update(up_o[0]),
    .fwd_idx(fi_o[0]), .bwd_idx(bi_o[0]), .iter_cnt(ic_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  train_seq_ctrl #(.BATCH_SIZE(1), .IDX_W(4), .ITER_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .num_iter(num_iter),
    .valid_zero_grad(vld[0]), .valid_forward(vld[1]),
    .valid_backward(vld[2]), .valid_update(vld[3]),
    .zero_grad(zg_o[1]), .run_forward(rf_o[1]), .run_backward(rb_o[1]),
    .load_backward(lb_o[1]), .update(up_o[1]),
    .fwd_idx(fi_o[1]), .bwd_idx(bi_o[1]), .iter_cnt(ic_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  assign zg   = zg_o[sel];
  assign rf   = rf_o[sel];
  assign rb   = rb_o[sel];
  assign lb   = lb_o[sel];
  assign up   = up_o[sel];
  assign busy = busy_o[sel];
  assign done = done_o[sel];
  assign fi   = fi_o[sel];
  assign bi   = bi_o[sel];
  assign ic   = ic_o[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int unsigned mx(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Cycle cost of a run: each handshake phase lasts as long as its slowest
  // responder, each release as long as its longest hold plus one cycle.
  function automatic int unsigned model_busy(input bit s, input int unsigned n);
    int unsigned b;
    int unsigned per_iter;
    b = s ? 1 : 2;
    per_iter = mx(dly[0], dly[1]) + mx(hold[0], hold[1]) + 1
             + (b - 1) * (1 + mx(dly[1], dly[2]) + mx(hold[1], hold[2]) + 1)
             + 1
             + dly[2] + hold[2] + 1
             + dly[3] + hold[3] + 1;
    return n * per_iter;
  endfunction

  // Event codes: 100+10*fwd zero_grad+fwd, 200 load, 300+10*fwd+bwd step,
  // 400+bwd last backward, 500 update.
  function automatic void build_exp(input bit s, input int unsigned n);
    int unsigned b;
    b = s ? 1 : 2;
    exp_q.delete();
    for (int unsigned it = 0; it < n; it++) begin
      exp_q.push_back(100);
      for (int unsigned k = 1; k < b; k++) begin
        exp_q.push_back(200);
        exp_q.push_back(int'(300 + 10 * k + (k - 1)));
      end
      exp_q.push_back(200);
      exp_q.push_back(int'(400 + (b - 1)));
      exp_q.push_back(500);
    end
  endfunction

  // Monitor then responders, in one process so the monitor sees the valids
  // the DUT sampled at the preceding rising edge.
  initial begin
    vld = '0;
    prev_vec = '0; prev_r4 = '0; prev_fi = '0; prev_bi = '0;
    plen = 0; last_step_len = 0;
    busy_cnt = 0; done_cnt = 0; iter_at_done = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      rcnt[i] = 0; hcnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      vec = {zg, rf, lb, rb, up};
      r4  = {up, rb, rf, zg};
      if (rst_n) begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          iter_at_done = ic;
          check("busy low with done", busy, 1'b0);
        end
        for (int unsigned i = 0; i < 4; i++) begin
          if (r4[i] && !prev_r4[i]) check($sformatf("req%0d rises with valid low", i), vld[i], 1'b0);
        end
        if (lb && !prev_vec[2]) check("valids low at load", vld, 4'b0);
        if (vec == prev_vec && vec != '0) begin
          check("fwd_idx stable", fi, prev_fi);
          check("bwd_idx stable", bi, prev_bi);
        end
        if (vec != prev_vec && vec != '0) begin
          case (vec)
            5'b11000: ev_q.push_back(100 + 10 * int'(fi));
            5'b00100: ev_q.push_back(200);
            5'b01010: ev_q.push_back(300 + 10 * int'(fi) + int'(bi));
            5'b00010: ev_q.push_back(400 + int'(bi));
            5'b00001: ev_q.push_back(500);
            default:  ev_q.push_back(999);
          endcase
        end
      end
      if (vec != prev_vec) begin
        if (prev_vec == 5'b01010) last_step_len = plen;
        plen = 1;
      end else begin
        plen++;
      end
      prev_vec = vec; prev_r4 = r4; prev_fi = fi; prev_bi = bi;

      for (int unsigned i = 0; i < 4; i++) begin
        if (!rst_n) begin
          vld[i] = 1'b0; rcnt[i] = 0; hcnt[i] = 0;
        end else if (!vld[i]) begin
          if (r4[i]) begin
            rcnt[i]++;
            if (rcnt[i] >= dly[i]) begin
              vld[i] = 1'b1; hcnt[i] = 0;
            end
          end else begin
            rcnt[i] = 0;
          end
        end else begin
          if (!r4[i]) begin
            hcnt[i]++;
            if (hcnt[i] > hold[i]) begin
              vld[i] = 1'b0; rcnt[i] = 0;
            end
          end else begin
            hcnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic set_resp(input int unsigned d, input int unsigned h);
    for (int unsigned i = 0; i < 4; i++) begin
      dly[i] = d; hold[i] = h;
    end
  endtask

  task automatic run_case(input string name, input bit s, input int unsigned n,
                          input int unsigned exp_busy, input int unsigned exp_iter, input bit poke);
    bit seen;
    int unsigned nev;
    @(negedge clk); #1;
    sel = s; num_iter = 16'(n);
    busy_cnt = 0; done_cnt = 0; iter_at_done = 0;
    ev_q.delete();
    build_exp(s, n);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    if (n == 0) check({name, " immediate done"}, {done, busy, zg, rf, lb, rb, up}, 7'b1000000);
    else        check({name, " first cycle"}, {busy, zg, rf, lb, rb, up}, 6'b111000);
    seen = done;
    for (int unsigned c = 0; c < 5000 && !seen; c++) begin
      if (poke && c == 2) begin
        start = 1'b1; num_iter = 16'(n + 5);
      end
      if (poke && c == 3) start = 1'b0;
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: done not seen within 5000 cycles", name);
    end
    check({name, " busy cycles"}, busy_cnt, exp_busy);
    check({name, " iter_cnt at done"}, iter_at_done, exp_iter);
    @(negedge clk); #1;
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " idle after done"}, {done, busy}, 2'b00);
    check({name, " event count"}, ev_q.size(), exp_q.size());
    nev = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int unsigned i = 0; i < nev; i++) begin
      check($sformatf("%s event %0d", name, i), ev_q[i], exp_q[i]);
    end
  endtask

  typedef struct {
    string       name;
    bit          s;
    int unsigned n;
    int unsigned d;
    int unsigned h;
    int unsigned busy;
    int unsigned iter;
  } row_t;

  row_t rows [8];

  initial begin
    bit          found;
    bit          rs;
    int unsigned rn;

    rows[0] = '{"nominal",     1'b0, 1, 3, 0, 18, 1};
    rows[1] = '{"multi3",      1'b0, 3, 3, 0, 54, 3};
    rows[2] = '{"min_iter",    1'b0, 1, 1, 0, 10, 1};
    rows[3] = '{"hold2",       1'b0, 2, 1, 2, 36, 2};
    rows[4] = '{"zero_iter",   1'b0, 0, 1, 0,  0, 0};
    rows[5] = '{"b1_nominal",  1'b1, 1, 3, 0, 13, 1};
    rows[6] = '{"b1_hold",     1'b1, 2, 2, 1, 26, 2};
    rows[7] = '{"b1_zero",     1'b1, 0, 1, 0,  0, 0};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; num_iter = '0;
    set_resp(1, 0);
    repeat (3) @(negedge clk);
    #1;
    check("reset state b2", {zg_o[0], rf_o[0], lb_o[0], rb_o[0], up_o[0], busy_o[0], done_o[0], fi_o[0], bi_o[0], ic_o[0]}, '0);
    check("reset state b1", {zg_o[1], rf_o[1], lb_o[1], rb_o[1], up_o[1], busy_o[1], done_o[1], fi_o[1], bi_o[1], ic_o[1]}, '0);
    rst_n = 1'b1;

    foreach (rows[i]) begin
      set_resp(rows[i].d, rows[i].h);
      run_case(rows[i].name, rows[i].s, rows[i].n, rows[i].busy, rows[i].iter, 1'b0);
    end

    // Forward acks early, backward late; responders hold valid 5 cycles
    dly[0] = 2; dly[1] = 2; dly[2] = 40; dly[3] = 2;
    for (int unsigned i = 0; i < 4; i++) hold[i] = 5;
    last_step_len = 0;
    run_case("mismatch", 1'b0, 1, 110, 1, 1'b0);
    check("mismatch step length", last_step_len, 40);

    set_resp(1, 0);
    run_case("start_while_busy", 1'b0, 2, 20, 2, 1'b1);

    set_resp(3, 0);
    @(negedge clk); #1;
    sel = 1'b0; num_iter = 16'd2; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int unsigned c = 0; c < 200 && !found; c++) begin
      @(negedge clk); #1;
      if (up) found = 1'b1;
    end
    check("reset test reaches update", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-run outputs", {zg, rf, lb, rb, up, busy, done, fi, bi, ic}, '0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_case("post_reset", 1'b0, 1, 18, 1, 1'b0);

    for (int unsigned r = 0; r < 10; r++) begin
      rs = 1'($urandom_range(0, 1));
      rn = $urandom_range(0, 3);
      for (int unsigned i = 0; i < 4; i++) begin
        dly[i]  = $urandom_range(1, 5);
        hold[i] = $urandom_range(0, 3);
      end
      run_case($sformatf("rand%0d", r), rs, rn, model_busy(rs, rn), rn, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
